inv_cov_from_inv_chol_2: RTL and testbench
==========================================

Name: inv_cov_from_inv_chol_2

Overview:
- Downstream consumer of the 2x2 "Inverse-Cholesky" stage.
- Input packs S_11 = 1/L_11, S_21 = L_21 and S_22 = 1/L_22.
- The block forms inv(L), then outputs the lower triangle of the symmetric inverse covariance P = inv(A) = inv(L)^T * inv(L).
- All data is signed Q16.16. One internal pipelined multiplier and one adder are time-shared under a fixed-schedule FSM.

Parameters:
- MULT_LAT, 2, pipeline depth of the internal signed 32x32 multiplier (legal 1..6).
- COUNT_WIDTH, 8, width of the step/cycle counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- clk_en  input  1  global enable. When low, all registers, the multiplier pipeline and the counters hold.
- S  input  96  [31:0]=S_11, [63:32]=S_21, [95:64]=S_22. Q16.16 signed.
- S_valid  input  1  level signal from the upstream stage. It stays high until that stage's next job.
- P  output  96  [31:0]=P_11, [63:32]=P_21, [95:64]=P_22. Q16.16 signed.
- P_valid  output  1  high from result until the next accepted job.
- busy  output  1  high while a job is in progress.

Behaviour:
- Reset values: P=0, P_valid=0, busy=0, FSM=IDLE, counters=0. The S_valid edge-detect register is cleared to 0.
- Job start:
  - Accept only in IDLE, on the rising edge S_valid & ~S_valid_d1, with clk_en=1.
  - On acceptance, latch S into internal registers, clear P_valid, set busy.
- Edges outside IDLE are ignored and not queued. A held-high S_valid triggers exactly one job.
- Multiply rule: 64-bit signed product, result = product[47:16] (truncate toward -inf).
- Negation rule: two's complement.
- States, one multiply each (operands registered at state entry, result captured MULT_LAT cycles later; each state lasts MULT_LAT+1 cycles):
  - M1: t = S_21*S_11
  - M2: u = t*S_22, then n = -u (n = inv(L)_21)
  - M3: P_22 = S_22*S_22
  - M4: P_21 = n*S_22
  - M5: q = n*n
  - M6: r = S_11*S_11
  - ADD (1 cycle): P_11 = r + q
  - DONE (1 cycle): drive P, P_valid<=1, busy<=0, then return to IDLE.
- Latency with clk_en continuously high: P_valid rises exactly 6*(MULT_LAT+1)+2 cycles after the accepting edge (20 cycles at default).
- P updates as a single 96-bit assignment in DONE. Intermediate values are never visible on P.
- P and P_valid hold after DONE until the next accepted job or rst.
- clk_en low stalls every stage and counter. Latency extends by exactly the number of stalled cycles.
- rst mid-job: abort immediately and return to reset values. A subsequent S_valid rising edge starts a clean job.
- Simultaneous rst and S_valid rise: rst wins, and the edge is not remembered.

Optional Feature:
- Macro: INV_COV_SAT_EN.
- Defined:
  - Multiply: if product[63:47] is not all equal, saturate to 0x7FFFFFFF (sign 0) or 0x80000000 (sign 1).
  - Negation: -0x80000000 gives 0x7FFFFFFF.
  - ADD: signed overflow saturates the same way.
- Undefined: plain truncation and two's-complement wrap in all three places. No extra logic is generated.

Test Plan:
- A=[[4,2],[2,5]] case: S_11=0x00008000, S_21=0x00010000, S_22=0x00008000, S_valid rise -> after 20 cycles P_11=0x00005000, P_21=0xFFFFE000, P_22=0x00004000, P_valid=1, busy=0.
- Identity: S=(0x00010000, 0x00000000, 0x00010000) -> P=(0x00010000, 0x00000000, 0x00010000) at cycle 20.
- Overflow: S_11=0x7FFF0000, S_21=0, S_22=0x00010000:
  - with INV_COV_SAT_EN: P_11=0x7FFFFFFF.
  - without it: P_11=0x00010000.
  - Both: P_21=0, P_22=0x00010000.
- S_valid held high 100 cycles, with S changed mid-hold -> exactly one job; P reflects the S latched at the edge. A second rise after DONE starts a new job.
- clk_en low for 5 cycles starting at cycle 8 of a job -> P_valid rises at cycle 25 with the same values as the unstalled run.
- rst pulsed at cycle 10 of a job -> P=0, P_valid=0, busy=0 next cycle. A new S_valid rise completes normally in 20 cycles.

Source files
------------

// File: rtl/inv_cov_from_inv_chol_2.sv
`default_nettype none
// ============================================================================
//  Module   : inv_cov_from_inv_chol_2
//  Purpose  : Takes the packed output of a 2x2 inverse-Cholesky stage
//             (S_11 = 1/L_11, S_21 = L_21, S_22 = 1/L_22) and produces the
//             lower triangle of the inverse covariance P = inv(L)^T * inv(L).
//             A single pipelined signed 32x32 multiplier and one adder are
//             time-shared by a fixed-schedule FSM. All data is signed Q16.16.
//
//             The schedule, one multiply per state:
//               M1 : t    = S_21 * S_11
//               M2 : n    = -(t * S_22)          (n = inv(L)_21)
//               M3 : P_22 = S_22 * S_22
//               M4 : P_21 = n * S_22
//               M5 : q    = n * n
//               M6 : r    = S_11 * S_11
//               ADD: P_11 = r + q
//               DONE: publish P, raise P_valid, drop busy
//
//  Ports    : clk      - clock
//             rst      - synchronous active-high reset
//             clk_en   - global enable; low freezes every register
//             S[95:0]  - {S_22, S_21, S_11}, Q16.16 signed
//             S_valid  - level valid; a job starts on its rising edge in IDLE
//             P[95:0]  - {P_22, P_21, P_11}, Q16.16 signed
//             P_valid  - high from result until the next accepted job
//             busy     - high while a job is in progress
//
//  Options  : `define INV_COV_SAT_EN to saturate the multiply, negation and
//             add instead of truncating / wrapping.
//
//  Revision : 1.0 - initial release
// ============================================================================
module inv_cov_from_inv_chol_2 #(
    parameter int MULT_LAT    = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [95:0] S,
    input  logic        S_valid,
    output logic [95:0] P,
    output logic        P_valid,
    output logic        busy
);

    localparam logic [COUNT_WIDTH-1:0] c_CNT_LAST = COUNT_WIDTH'(MULT_LAT);
    localparam logic [31:0]            c_SAT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0]            c_SAT_MIN  = 32'h8000_0000;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_M1   = 4'd1,
        ST_M2   = 4'd2,
        ST_M3   = 4'd3,
        ST_M4   = 4'd4,
        ST_M5   = 4'd5,
        ST_M6   = 4'd6,
        ST_ADD  = 4'd7,
        ST_DONE = 4'd8
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                   state_q,  state_d;
    logic [COUNT_WIDTH-1:0]   cnt_q,    cnt_d;
    logic                     sv_d1_q,  sv_d1_d;
    logic [31:0]              s11_q,    s11_d;
    logic [31:0]              s21_q,    s21_d;
    logic [31:0]              s22_q,    s22_d;
    logic [31:0]              opa_q,    opa_d;
    logic [31:0]              opb_q,    opb_d;
    logic [31:0]              pipe_q [MULT_LAT];
    logic [31:0]              pipe_d [MULT_LAT];
    logic [31:0]              n_q,      n_d;
    logic [31:0]              qq_q,     qq_d;
    logic [31:0]              rr_q,     rr_d;
    logic [31:0]              p11_q,    p11_d;
    logic [31:0]              p21_q,    p21_d;
    logic [31:0]              p22_q,    p22_d;
    logic [95:0]              p_q,      p_d;
    logic                     pvalid_q, pvalid_d;
    logic                     busy_q,   busy_d;

    // ------------------------------------------------------------------------
    // Shared arithmetic
    // ------------------------------------------------------------------------
    logic signed [63:0] w_prod;
    logic [31:0]        w_mul_res;   // product after Q16.16 rescale
    logic [31:0]        w_mul_out;   // result leaving the multiplier pipeline
    logic [31:0]        w_neg_res;
    logic [31:0]        w_sum;
    logic               w_unused_prod;
    logic               w_step_done;

    assign w_prod = 64'(signed'(opa_q)) * 64'(signed'(opb_q));

    // The rescale is folded into the first pipeline stage; later stages only
    // delay it, so the operands-to-result latency is exactly MULT_LAT.
    always_comb begin
        w_mul_res = w_prod[47:16];
`ifdef INV_COV_SAT_EN
        if (w_prod[63:47] != {17{w_prod[63]}}) begin
            w_mul_res = w_prod[63] ? c_SAT_MIN : c_SAT_MAX;
        end
`endif
    end

`ifdef INV_COV_SAT_EN
    assign w_unused_prod = ^w_prod[15:0];
`else
    assign w_unused_prod = ^{w_prod[63:48], w_prod[15:0]};
`endif

    assign w_mul_out = pipe_q[MULT_LAT-1];

    always_comb begin
        w_neg_res = 32'd0 - w_mul_out;
`ifdef INV_COV_SAT_EN
        if (w_mul_out == c_SAT_MIN) begin
            w_neg_res = c_SAT_MAX;
        end
`endif
    end

    always_comb begin
        w_sum = rr_q + qq_q;
`ifdef INV_COV_SAT_EN
        if ((rr_q[31] == qq_q[31]) && (w_sum[31] != rr_q[31])) begin
            w_sum = rr_q[31] ? c_SAT_MIN : c_SAT_MAX;
        end
`endif
    end

    assign w_step_done = (cnt_q == c_CNT_LAST);

    // ------------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sv_d1_d  = S_valid;
        s11_d    = s11_q;
        s21_d    = s21_q;
        s22_d    = s22_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        n_d      = n_q;
        qq_d     = qq_q;
        rr_d     = rr_q;
        p11_d    = p11_q;
        p21_d    = p21_q;
        p22_d    = p22_q;
        p_d      = p_q;
        pvalid_d = pvalid_q;
        busy_d   = busy_q;

        pipe_d[0] = w_mul_res;
        for (int i = 1; i < MULT_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // Each multiply state lasts MULT_LAT+1 cycles.
        if ((state_q >= ST_M1) && (state_q <= ST_M6)) begin
            cnt_d = w_step_done ? '0 : cnt_q + 1'b1;
        end

        // Operands for the next multiply are loaded on the same edge that
        // leaves the current state, so the next state starts with them in
        // place. M2 needs t, which is taken straight off the pipeline output.
        case (state_q)
            ST_IDLE: begin
                if (S_valid && !sv_d1_q) begin
                    state_d  = ST_M1;
                    cnt_d    = '0;
                    s11_d    = S[31:0];
                    s21_d    = S[63:32];
                    s22_d    = S[95:64];
                    opa_d    = S[63:32];
                    opb_d    = S[31:0];
                    pvalid_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_M1: begin
                if (w_step_done) begin
                    state_d = ST_M2;
                    opa_d   = w_mul_out;
                    opb_d   = s22_q;
                end
            end
            ST_M2: begin
                if (w_step_done) begin
                    state_d = ST_M3;
                    n_d     = w_neg_res;
                    opa_d   = s22_q;
                    opb_d   = s22_q;
                end
            end
            ST_M3: begin
                if (w_step_done) begin
                    state_d = ST_M4;
                    p22_d   = w_mul_out;
                    opa_d   = n_q;
                    opb_d   = s22_q;
                end
            end
            ST_M4: begin
                if (w_step_done) begin
                    state_d = ST_M5;
                    p21_d   = w_mul_out;
                    opa_d   = n_q;
                    opb_d   = n_q;
                end
            end
            ST_M5: begin
                if (w_step_done) begin
                    state_d = ST_M6;
                    qq_d    = w_mul_out;
                    opa_d   = s11_q;
                    opb_d   = s11_q;
                end
            end
            ST_M6: begin
                if (w_step_done) begin
                    state_d = ST_ADD;
                    rr_d    = w_mul_out;
                end
            end
            ST_ADD: begin
                state_d = ST_DONE;
                p11_d   = w_sum;
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                p_d      = {p22_q, p21_q, p11_q};
                pvalid_d = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sv_d1_q  <= 1'b0;
            s11_q    <= '0;
            s21_q    <= '0;
            s22_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            n_q      <= '0;
            qq_q     <= '0;
            rr_q     <= '0;
            p11_q    <= '0;
            p21_q    <= '0;
            p22_q    <= '0;
            p_q      <= '0;
            pvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < MULT_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (clk_en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sv_d1_q  <= sv_d1_d;
            s11_q    <= s11_d;
            s21_q    <= s21_d;
            s22_q    <= s22_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            n_q      <= n_d;
            qq_q     <= qq_d;
            rr_q     <= rr_d;
            p11_q    <= p11_d;
            p21_q    <= p21_d;
            p22_q    <= p22_d;
            p_q      <= p_d;
            pvalid_q <= pvalid_d;
            busy_q   <= busy_d;
            for (int i = 0; i < MULT_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign P       = p_q;
    assign P_valid = pvalid_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_cov_from_inv_chol_2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_cov_from_inv_chol_2
//  Purpose  : Self-checking bench for inv_cov_from_inv_chol_2 with a
//             plain-arithmetic reference model of P = inv(L)^T * inv(L).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inv_cov_from_inv_chol_2;

    localparam int ML      = 2;
    localparam int LAT_EXP = 6 * (ML + 1) + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [95:0] S;
    logic        S_valid;
    logic [95:0] P;
    logic        P_valid;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    inv_cov_from_inv_chol_2 #(.MULT_LAT(ML), .COUNT_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .S       (S),
        .S_valid (S_valid),
        .P       (P),
        .P_valid (P_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Reference model: real-valued Q16.16 arithmetic on 64-bit integers
    // ------------------------------------------------------------------------
    function automatic logic [31:0] clamp_or_wrap(input longint v);
        logic [63:0] w;
`ifdef INV_COV_SAT_EN
        if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
        w = v;
        return w[31:0];
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        return clamp_or_wrap(p >>> 16);   // floor(a*b / 2^16)
    endfunction

    function automatic logic [31:0] m_neg(input logic [31:0] a);
        return clamp_or_wrap(-longint'(signed'(a)));
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        return clamp_or_wrap(longint'(signed'(a)) + longint'(signed'(b)));
    endfunction

    function automatic logic [95:0] model_p(input logic [95:0] s);
        logic [31:0] s11, s21, s22, n;
        s11 = s[31:0];
        s21 = s[63:32];
        s22 = s[95:64];
        n   = m_neg(m_mul(m_mul(s21, s11), s22));
        return {m_mul(s22, s22), m_mul(n, s22), m_add(m_mul(s11, s11), m_mul(n, n))};
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] v;
        v = $urandom;
        return 32'(signed'(v) >>> $urandom_range(4, 20));
    endfunction

    // ------------------------------------------------------------------------
    // Job driver: lowers S_valid, raises it with s, then counts edges after
    // the accepting edge until P_valid. Optional clk_en stall window and a
    // mid-job scramble of S. Results are returned for the caller to check.
    // ------------------------------------------------------------------------
    task automatic do_job(input logic [95:0] s, input bit scramble,
                          input int st_start, input int st_len,
                          output int lat, output bit early_busy,
                          output bit early_pv, output bit p_stable);
        logic [95:0] p_before;
        @(negedge clk);
        S_valid = 1'b0;
        clk_en  = 1'b1;
        @(negedge clk);
        S        = s;
        S_valid  = 1'b1;
        p_before = P;
        @(posedge clk);
        #1;
        early_busy = busy;
        early_pv   = P_valid;
        lat        = 0;
        p_stable   = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            if (scramble && lat == 5) S = {$urandom, $urandom, $urandom};
            clk_en = !((lat + 1 >= st_start) && (lat + 1 < st_start + st_len));
            @(posedge clk);
            #1;
            lat++;
            if (P_valid) break;
            if (P !== p_before) p_stable = 1'b0;
        end
        clk_en = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; S_valid = 1'b0; S = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (P !== 96'd0) begin tests_failed++; $display("FAIL reset_P: got %h expected 0", P); end
        tests_run++;
        if (P_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_P_valid: got %b expected 0", P_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known_vectors();
        logic [95:0] vin [3];
        logic [95:0] vexp[3];
        int lat; bit eb, ep, ps;
        vin[0]  = {32'h0000_8000, 32'h0001_0000, 32'h0000_8000};
        vexp[0] = {32'h0000_4000, 32'hFFFF_E000, 32'h0000_5000};
        vin[1]  = {32'h0001_0000, 32'h0000_0000, 32'h0001_0000};
        vexp[1] = {32'h0001_0000, 32'h0000_0000, 32'h0001_0000};
        vin[2]  = {32'h0001_0000, 32'h0000_0000, 32'h7FFF_0000};
`ifdef INV_COV_SAT_EN
        vexp[2] = {32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF};
`else
        vexp[2] = {32'h0001_0000, 32'h0000_0000, 32'h0001_0000};
`endif
        for (int k = 0; k < 3; k++) begin
            do_job(vin[k], 1'b0, 0, 0, lat, eb, ep, ps);
            tests_run++;
            if (lat !== LAT_EXP) begin tests_failed++; $display("FAIL known%0d_latency: got %0d expected %0d", k, lat, LAT_EXP); end
            tests_run++;
            if (P !== vexp[k]) begin tests_failed++; $display("FAIL known%0d_P: got %h expected %h", k, P, vexp[k]); end
            tests_run++;
            if (busy !== 1'b0) begin tests_failed++; $display("FAIL known%0d_busy_after: got %b expected 0", k, busy); end
            tests_run++;
            if (eb !== 1'b1 || ep !== 1'b0) begin tests_failed++; $display("FAIL known%0d_accept: busy=%b P_valid=%b expected busy=1 P_valid=0", k, eb, ep); end
            tests_run++;
            if (k > 0 && ps !== 1'b1) begin tests_failed++; $display("FAIL known%0d_P_hidden: got P change mid-job expected P held", k); end
        end
    endtask

    task automatic test_random();
        logic [95:0] s;
        int lat; bit eb, ep, ps;
        for (int k = 0; k < 10; k++) begin
            s = {rnd_word(), rnd_word(), rnd_word()};
            do_job(s, 1'b0, 0, 0, lat, eb, ep, ps);
            tests_run++;
            if (P !== model_p(s) || lat !== LAT_EXP) begin
                tests_failed++;
                $display("FAIL random%0d: got P=%h lat=%0d expected P=%h lat=%0d (S=%h)", k, P, lat, model_p(s), LAT_EXP, s);
            end
        end
    endtask

    task automatic test_hold_and_back_to_back();
        logic [95:0] s0, s1, p_done;
        int lat; bit eb, ep, ps;
        int busy_seen;
        s0 = {rnd_word(), rnd_word(), rnd_word()};
        do_job(s0, 1'b1, 0, 0, lat, eb, ep, ps);   // S_valid stays high
        tests_run++;
        if (P !== model_p(s0) || lat !== LAT_EXP) begin
            tests_failed++;
            $display("FAIL hold_first: got P=%h lat=%0d expected P=%h lat=%0d", P, lat, model_p(s0), LAT_EXP);
        end
        p_done    = P;
        busy_seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 10) S = {rnd_word(), rnd_word(), rnd_word()};
            if (busy) busy_seen++;
        end
        tests_run++;
        if (busy_seen !== 0 || P !== p_done || P_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_single_job: got busy_cycles=%0d P=%h P_valid=%b expected 0 %h 1", busy_seen, P, P_valid, p_done);
        end
        s1 = {rnd_word(), rnd_word(), rnd_word()};
        do_job(s1, 1'b0, 0, 0, lat, eb, ep, ps);
        tests_run++;
        if (P !== model_p(s1) || lat !== LAT_EXP) begin
            tests_failed++;
            $display("FAIL back_to_back: got P=%h lat=%0d expected P=%h lat=%0d", P, lat, model_p(s1), LAT_EXP);
        end
    endtask

    task automatic test_stall();
        logic [95:0] s;
        int lat; bit eb, ep, ps;
        s = {32'h0000_8000, 32'h0001_0000, 32'h0000_8000};
        do_job(s, 1'b0, 8, 5, lat, eb, ep, ps);
        tests_run++;
        if (lat !== LAT_EXP + 5) begin tests_failed++; $display("FAIL stall_latency: got %0d expected %0d", lat, LAT_EXP + 5); end
        tests_run++;
        if (P !== 96'h0000_4000_FFFF_E000_0000_5000) begin tests_failed++; $display("FAIL stall_P: got %h expected 00004000ffffe00000005000", P); end
    endtask

    task automatic test_rst_mid_job();
        logic [95:0] s;
        int lat; bit eb, ep, ps;
        @(negedge clk);
        S_valid = 1'b0;
        @(negedge clk);
        S = {rnd_word(), rnd_word(), rnd_word()};
        S_valid = 1'b1;
        @(posedge clk);                  // accepting edge
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        S_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (P !== 96'd0 || P_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_job: got P=%h P_valid=%b busy=%b expected 0 0 0", P, P_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        s = {rnd_word(), rnd_word(), rnd_word()};
        do_job(s, 1'b0, 0, 0, lat, eb, ep, ps);
        tests_run++;
        if (P !== model_p(s) || lat !== LAT_EXP) begin
            tests_failed++;
            $display("FAIL after_rst_job: got P=%h lat=%0d expected P=%h lat=%0d", P, lat, model_p(s), LAT_EXP);
        end
    endtask

    task automatic test_rst_with_edge();
        @(negedge clk);
        S_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        S_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        S_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || P_valid !== 1'b0 || P !== 96'd0) begin
            tests_failed++;
            $display("FAIL rst_wins: got busy=%b P_valid=%b P=%h expected 0 0 0", busy, P_valid, P);
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_random();
        test_hold_and_back_to_back();
        test_stall();
        test_rst_mid_job();
        test_rst_with_edge();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
